mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin arbiter and sequencer that shares one 4x4 unsigned array multiplier (`array4x4multipler`) among `NREQ` requesters. Each requester presents a 4-bit operand pair with a valid/ready handshake. The block grants one requester, latches its operands and drives them into the shared multiplier. It then returns the registered 8-bit product with the winner's index over a single response handshake. It sits between the requester ports and the multiplier datapath and is the only instantiator of the multiplier.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `ID_W`, default `$clog2(NREQ)`: width of the requester index.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `req_valid`, in, `NREQ`: bit i means requester i has an operand pair pending.
- `req_ready`, out, `NREQ`: one-hot grant; a handshake completes for i when `req_valid[i] && req_ready[i]`.
- `req_a`, in, `4*NREQ`: operand A; requester i occupies bits `[4i+3:4i]`.
- `req_b`, in, `4*NREQ`: operand B; same packing as `req_a`.
- `rsp_valid`, out, 1: product available.
- `rsp_ready`, in, 1: consumer accepts the product.
- `rsp_p`, out, 8: unsigned product A*B.
- `rsp_id`, out, `ID_W`: index of the requester that produced `rsp_p`.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - CALC: latched operands are applied to the multiplier.
  - RESP: product is held on the response port.
- IDLE:
  - If no `req_valid` bit is set, `req_ready` = 0 and the FSM stays in IDLE.
  - Otherwise a winner w is selected: the first set bit of `req_valid` scanning upward from `last+1` modulo `NREQ`.
  - `req_ready[w]` = 1 combinationally in the same cycle.
  - At the clock edge: `op_a`/`op_b` are latched from slice w, `id` <= w, `last` <= w, and the FSM moves to CALC.
- CALC:
  - `op_a`/`op_b` drive the multiplier inputs.
  - At the clock edge the multiplier output is registered into `rsp_p` and `rsp_id` <= `id`; the FSM moves to RESP.
- RESP:
  - `rsp_valid` = 1.
  - `rsp_p` and `rsp_id` hold stable until `rsp_ready` is sampled high; the FSM then moves to IDLE.
- `req_ready` is 0 in CALC and RESP. A requester may raise or drop `req_valid` freely while not granted.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that keeps `req_valid` high is guaranteed service within `NREQ` operations.
- Pointer wrap: `last` = `NREQ-1` makes requester 0 first in scan order.
- Arithmetic: unsigned 4x4 -> 8-bit product with no truncation; 15*15 = 225 fits.
- Multiplier inputs are driven only from the `op_a`/`op_b` registers, never directly from `req_a`/`req_b`.
- Reset (asserted in any state):
  - FSM -> IDLE; `rsp_valid`, `busy`, `rsp_p`, `rsp_id`, `op_a`, `op_b` -> 0; `last` -> `NREQ-1`.
  - Any in-flight product is discarded with no response.
  - `req_ready` = 0 whenever `rst` is high.

## Timing
- Reset values: `req_ready` = 0, `rsp_valid` = 0, `rsp_p` = 8'h00, `rsp_id` = 0, `busy` = 0.
- Request handshake at cycle T leads to `rsp_valid` rising at T+2: T = IDLE grant, T+1 = CALC, T+2 = first RESP cycle.
- With `rsp_ready` tied high, RESP lasts one cycle. The next grant is at T+3, so minimum issue interval is 3 cycles.
- Back-pressure: each cycle `rsp_ready` is low adds one cycle in RESP, with outputs held.
- `busy` is registered; it is 1 from T+1 up to and including the final RESP cycle.
- Critical combinational path is `op_a`/`op_b` -> multiplier -> `rsp_p` register.

## Structure
- Package `mult_arb_pkg`:
  - state enum `{IDLE, CALC, RESP}`;
  - constants `OP_W` = 4 and `PROD_W` = 8;
  - function `rr_pick(valid, last)` returning the winner index.
- One sub-module: the existing `array4x4multipler`, instantiated once as `u_mul`.
- Arbitration stays as the package function, not a separate module.

## Test plan
- Reset then idle: `rst` high for 2 cycles, no requests -> all outputs 0 and `busy` = 0 for 10 cycles.
- Single requester: req 2 with A=4'b1100, B=4'b1001 -> `req_ready` = 4'b0100 at T, `rsp_valid` at T+2 with `rsp_p` = 8'h6C (108) and `rsp_id` = 2.
- All four requesters valid continuously, `rsp_ready` = 1, with pairs req0=(8,4), req1=(4,6), req2=(15,7), req3=(13,15):
  - grant order 0,1,2,3,0;
  - products 32, 24, 105, 195;
  - issue interval exactly 3 cycles.
- Back-pressure: hold `rsp_ready` = 0 for 5 cycles in RESP with A=7, B=7 -> `rsp_p` = 49 stable throughout, `req_ready` = 0, and the next grant occurs one cycle after acceptance.
- Pointer wrap: after a grant to req3, assert req1 and req3 together -> req1 is granted next, then req3.
- Reset mid-operation: assert `rst` during CALC -> no `rsp_valid` follows. After release, req0 with (4,5) returns 20 with `rsp_id` = 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
// Shared types and helpers for the multiplier-sharing arbiter.
//   arb_state_e : sequencer states (IDLE / CALC / RESP)
//   OP_W        : operand width of the shared multiplier
//   PROD_W      : product width of the shared multiplier
//   MAX_REQ     : largest supported requester count
//   rr_pick()   : round-robin winner selection
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int OP_W    = 4;
    localparam int PROD_W  = 8;
    localparam int MAX_REQ = 8;

    // Returns the first set bit of valid scanning upward from last+1,
    // wrapping at nreq. Only meaningful when at least one valid bit is set.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         last,
                                           input int                 nreq);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(last) + i) % nreq;
            if (!found && (i <= nreq) && valid[3'(idx)]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/array4x4multipler.sv
// array4x4multipler
// Unsigned 4x4 array multiplier, purely combinational.
//   a : operand A (4 bits)
//   b : operand B (4 bits)
//   p : product A*B (8 bits, no truncation)
module array4x4multipler
    import mult_arb_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    logic [OP_W-1:0]   pp0, pp1, pp2, pp3;
    logic [PROD_W-1:0] acc0, acc1, acc2, acc3;

    // One partial-product row per bit of B, accumulated row by row.
    assign pp0 = a & {OP_W{b[0]}};
    assign pp1 = a & {OP_W{b[1]}};
    assign pp2 = a & {OP_W{b[2]}};
    assign pp3 = a & {OP_W{b[3]}};

    assign acc0 = {4'b0000, pp0};
    assign acc1 = acc0 + {3'b000, pp1, 1'b0};
    assign acc2 = acc1 + {2'b00, pp2, 2'b00};
    assign acc3 = acc2 + {1'b0, pp3, 3'b000};

    assign p = acc3;

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Round-robin arbiter that shares one 4x4 multiplier among NREQ requesters.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req_valid : per-requester operand pair pending
//   req_ready : one-hot grant (IDLE only)
//   req_a     : packed operand A, requester i at [4i+3:4i]
//   req_b     : packed operand B, same packing
//   rsp_valid : product available
//   rsp_ready : consumer accepts product
//   rsp_p     : registered 8-bit product
//   rsp_id    : index of the requester that produced rsp_p
//   busy      : registered, high whenever not in IDLE
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no operation in flight, grant issued here
// CALC  | latched operands applied to the multiplier
// RESP  | product held on the response port
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [OP_W*NREQ-1:0] req_a,
    input  logic [OP_W*NREQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PROD_W-1:0]    rsp_p,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    arb_state_e          state_q, state_d;
    logic [OP_W-1:0]     op_a_q, op_a_d;
    logic [OP_W-1:0]     op_b_q, op_b_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [PROD_W-1:0]   rsp_p_q, rsp_p_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                busy_q, busy_d;

    logic [MAX_REQ-1:0]  valid_ext;
    logic [ID_W-1:0]     win_id;
    logic                grant;
    logic [PROD_W-1:0]   mul_p;

    always_comb begin
        valid_ext            = '0;
        valid_ext[NREQ-1:0]  = req_valid;
    end

    assign win_id = ID_W'(rr_pick(valid_ext, 3'(last_q), NREQ));
    // Grant is suppressed during reset so nothing handshakes into a flushed FSM.
    assign grant  = (state_q == IDLE) && (|req_valid) && !rst;

    // Multiplier sees only the latched operands, keeping the request ports
    // off the critical op -> multiplier -> rsp_p path.
    array4x4multipler u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (mul_p)
    );

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            id_q     <= '0;
            last_q   <= ID_W'(NREQ - 1);
            rsp_p_q  <= '0;
            rsp_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            id_q     <= id_d;
            last_q   <= last_d;
            rsp_p_q  <= rsp_p_d;
            rsp_id_q <= rsp_id_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        id_d     = id_q;
        last_d   = last_q;
        rsp_p_d  = rsp_p_q;
        rsp_id_d = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = CALC;
                    op_a_d  = req_a[OP_W*int'(win_id) +: OP_W];
                    op_b_d  = req_b[OP_W*int'(win_id) +: OP_W];
                    id_d    = win_id;
                    last_d  = win_id;
                end
            end
            CALC: begin
                state_d  = RESP;
                rsp_p_d  = mul_p;
                rsp_id_d = id_q;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Outputs
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_id] = 1'b1;
        end
        rsp_valid = (state_q == RESP);
        rsp_p     = rsp_p_q;
        rsp_id    = rsp_id_q;
        busy      = busy_q;
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_p;
    logic [1:0]  rsp_id;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    mult_share_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // Scoreboard: push the bench-computed product at each request handshake,
    // pop and compare at each response handshake. Reset discards in-flight work.
    always @(negedge clk) begin
        logic [9:0] exp_v;
        int         prod;
        if (rst) begin
            sb.delete();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    prod = int'(req_a[4*i +: 4]) * int'(req_b[4*i +: 4]);
                    sb.push_back({2'(i), 8'(prod)});
                end
            end
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got id=%0d p=%0d, required no response", rsp_id, rsp_p);
                end else begin
                    exp_v = sb.pop_front();
                    if ({rsp_id, rsp_p} !== exp_v) begin
                        n_err++;
                        $display("FAIL sb_product: got id=%0d p=%0d, required id=%0d p=%0d",
                                 rsp_id, rsp_p, exp_v[9:8], exp_v[7:0]);
                    end
                end
            end
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        repeat (2) begin
            wait_cycle();
            #1;
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_ready: got %b, required 0000", req_ready);
            end
        end
        wait_cycle();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if ({req_ready, rsp_valid, rsp_p, rsp_id, busy} !== 16'h0000) begin
                n_err++;
                $display("FAIL reset_idle: got ready=%b v=%b p=%h id=%0d busy=%b, required all 0",
                         req_ready, rsp_valid, rsp_p, rsp_id, busy);
            end
            wait_cycle();
        end
    endtask

    task automatic test_single();
        set_op(2, 4'b1100, 4'b1001);
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL single_grant: got %b, required 0100", req_ready);
        end
        wait_cycle();
        req_valid = '0;
        #1;
        n_cmp++;
        if ({rsp_valid, busy, req_ready} !== 6'b010000) begin
            n_err++;
            $display("FAIL single_calc: got v=%b busy=%b ready=%b, required v=0 busy=1 ready=0000",
                     rsp_valid, busy, req_ready);
        end
        wait_cycle();
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_p, rsp_id, busy} !== {1'b1, 8'h6C, 2'd2, 1'b1}) begin
            n_err++;
            $display("FAIL single_resp: got v=%b p=%h id=%0d busy=%b, required v=1 p=6c id=2 busy=1",
                     rsp_valid, rsp_p, rsp_id, busy);
        end
        wait_cycle();
        #1;
        n_cmp++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL single_done: got v=%b busy=%b, required 0 0", rsp_valid, busy);
        end
        wait_cycle();
    endtask

    task automatic test_all_four();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int k;
        int prev_c;
        int g;
        rst = 1'b1;
        wait_cycle();
        rst = 1'b0;
        set_op(0, 4'd8, 4'd4);
        set_op(1, 4'd4, 4'd6);
        set_op(2, 4'd15, 4'd7);
        set_op(3, 4'd13, 4'd15);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        k      = 0;
        prev_c = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                g = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                n_cmp++;
                if (!$onehot(req_ready) || g != exp_order[k]) begin
                    n_err++;
                    $display("FAIL rr_order: grant %0d got ready=%b, required requester %0d", k, req_ready, exp_order[k]);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (c - prev_c != 3) begin
                        n_err++;
                        $display("FAIL rr_interval: got %0d cycles, required 3", c - prev_c);
                    end
                end
                prev_c = c;
                k++;
                if (k == 5) break;
            end
            wait_cycle();
        end
        n_cmp++;
        if (k != 5) begin
            n_err++;
            $display("FAIL rr_count: got %0d grants within bound, required 5", k);
        end
        wait_cycle();
        req_valid = '0;
        repeat (6) wait_cycle();
    endtask

    task automatic test_backpressure();
        set_op(1, 4'd7, 4'd7);
        set_op(3, 4'd13, 4'd15);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_grant: got %b, required 0010", req_ready);
        end
        wait_cycle();
        req_valid = 4'b1000;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL bp_calc_ready: got %b, required 0000", req_ready);
        end
        wait_cycle();
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({rsp_valid, rsp_p, rsp_id, req_ready} !== {1'b1, 8'd49, 2'd1, 4'b0000}) begin
                n_err++;
                $display("FAIL bp_hold: cycle %0d got v=%b p=%0d id=%0d ready=%b, required v=1 p=49 id=1 ready=0000",
                         c, rsp_valid, rsp_p, rsp_id, req_ready);
            end
            wait_cycle();
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_p, req_ready} !== {1'b1, 8'd49, 4'b0000}) begin
            n_err++;
            $display("FAIL bp_accept: got v=%b p=%0d ready=%b, required v=1 p=49 ready=0000",
                     rsp_valid, rsp_p, req_ready);
        end
        wait_cycle();
        #1;
        n_cmp++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL bp_next_grant: got %b, required 1000", req_ready);
        end
        wait_cycle();
        req_valid = '0;
        repeat (6) wait_cycle();
    endtask

    task automatic test_wrap();
        int gc;
        set_op(1, 4'd5, 4'd6);
        set_op(3, 4'd2, 4'd3);
        rsp_ready = 1'b1;
        req_valid = 4'b1010;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL wrap_first: got %b, required 0010", req_ready);
        end
        gc = -1;
        for (int c = 1; c <= 6; c++) begin
            wait_cycle();
            #1;
            if (req_ready !== 4'b0000) begin
                gc = c;
                break;
            end
        end
        n_cmp++;
        if (gc != 3 || req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL wrap_second: got ready=%b at +%0d, required 1000 at +3", req_ready, gc);
        end
        wait_cycle();
        req_valid = '0;
        repeat (6) wait_cycle();
    endtask

    task automatic test_reset_mid();
        set_op(2, 4'd9, 4'd9);
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL rm_grant: got %b, required 0100", req_ready);
        end
        wait_cycle();
        rst       = 1'b1;
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_err++;
            $display("FAIL rm_ready_in_rst: got %b, required 0000", req_ready);
        end
        wait_cycle();
        rst       = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if ({rsp_valid, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL rm_no_resp: cycle %0d got v=%b busy=%b, required 0 0", c, rsp_valid, busy);
            end
            wait_cycle();
        end
        set_op(0, 4'd4, 4'd5);
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL rm_regrant: got %b, required 0001", req_ready);
        end
        wait_cycle();
        req_valid = '0;
        wait_cycle();
        #1;
        n_cmp++;
        if ({rsp_valid, rsp_p, rsp_id} !== {1'b1, 8'd20, 2'd0}) begin
            n_err++;
            $display("FAIL rm_result: got v=%b p=%0d id=%0d, required v=1 p=20 id=0", rsp_valid, rsp_p, rsp_id);
        end
        repeat (4) wait_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
